// File: rtl/snax_alu_csr_mgr_pkg.sv
// ============================================================================
// Module  : snax_alu_csr_mgr_pkg
// Brief   : Shared FSM state type for the SNAX ALU CSR manager.
// Revision: 1.0
// ============================================================================
`default_nettype none

package snax_alu_csr_mgr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        RESP   = 2'd2
    } csr_mgr_state_e;

endpackage

`default_nettype wire

// File: rtl/snax_alu_csr_manager.sv
// ============================================================================
// Module  : snax_alu_csr_manager
// Brief   : Stages core CSR writes, commits the full set to the accelerator
//           on a write to the last RW register, and serves core reads.
// Revision: 1.0
// ============================================================================
`default_nettype none

module snax_alu_csr_manager
    import snax_alu_csr_mgr_pkg::*;
#(
    parameter int RegRWCount   = 3,
    parameter int RegROCount   = 2,
    parameter int RegDataWidth = 32,
    parameter int RegAddrWidth = 32
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [RegAddrWidth-1:0]                 csr_req_addr_i,
    input  logic [RegDataWidth-1:0]                 csr_req_data_i,
    input  logic                                    csr_req_write_i,
    input  logic                                    csr_req_valid_i,
    output logic                                    csr_req_ready_o,
    output logic [RegDataWidth-1:0]                 csr_rsp_data_o,
    output logic                                    csr_rsp_valid_o,
    input  logic                                    csr_rsp_ready_i,
    output logic [RegRWCount-1:0][RegDataWidth-1:0] csr_reg_set_o,
    output logic                                    csr_reg_set_valid_o,
    input  logic                                    csr_reg_set_ready_i,
    input  logic [RegROCount-1:0][RegDataWidth-1:0] csr_reg_ro_set_i
);

    localparam logic [RegAddrWidth-1:0] COMMIT_ADDR = RegAddrWidth'(RegRWCount - 1);
    localparam int                      RO_BASE     = RegRWCount;

    csr_mgr_state_e                         state;
    logic [RegRWCount-1:0][RegDataWidth-1:0] staging;
    logic [RegDataWidth-1:0]                 rsp_data;
    logic [RegDataWidth-1:0]                 read_data;
    logic                                    req_fire;

    // Ready is masked by reset so the core never sees a handshake during reset.
    assign csr_req_ready_o     = (state == IDLE) && !rst_i;
    assign req_fire            = csr_req_valid_i && csr_req_ready_o;
    assign csr_rsp_valid_o     = (state == RESP);
    assign csr_rsp_data_o      = rsp_data;
    assign csr_reg_set_valid_o = (state == COMMIT);
    assign csr_reg_set_o       = staging;

    // Full-width address compare: upper address bits never alias onto a register.
    always_comb begin
        read_data = '0;
        for (int i = 0; i < RegRWCount; i++) begin
            if (csr_req_addr_i == RegAddrWidth'(i)) begin
                read_data = staging[i];
            end
        end
        for (int j = 0; j < RegROCount; j++) begin
            if (csr_req_addr_i == RegAddrWidth'(RO_BASE + j)) begin
                read_data = csr_reg_ro_set_i[j];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            staging  <= '0;
            rsp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        if (csr_req_write_i) begin
                            for (int i = 0; i < RegRWCount; i++) begin
                                if (csr_req_addr_i == RegAddrWidth'(i)) begin
                                    staging[i] <= csr_req_data_i;
                                end
                            end
                            if (csr_req_addr_i == COMMIT_ADDR) begin
                                state <= COMMIT;
                            end
                        end else begin
                            rsp_data <= read_data;
                            state    <= RESP;
                        end
                    end
                end
                COMMIT: begin
                    if (csr_reg_set_ready_i) begin
                        state <= IDLE;
                    end
                end
                RESP: begin
                    if (csr_rsp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_snax_alu_csr_manager.sv
// ============================================================================
// Module  : tb_snax_alu_csr_manager
// Brief   : Directed, table-driven self-checking bench for the CSR manager.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_snax_alu_csr_manager;

    logic              clk;
    logic              rst;
    logic [31:0]       req_addr;
    logic [31:0]       req_data;
    logic              req_write;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       rsp_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0][31:0]  reg_set;
    logic              set_valid;
    logic              set_ready;
    logic [1:0][31:0]  ro_set;

    int nchecks = 0;
    int nerrors = 0;

    snax_alu_csr_manager #(
        .RegRWCount   (3),
        .RegROCount   (2),
        .RegDataWidth (32),
        .RegAddrWidth (32)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .csr_req_addr_i      (req_addr),
        .csr_req_data_i      (req_data),
        .csr_req_write_i     (req_write),
        .csr_req_valid_i     (req_valid),
        .csr_req_ready_o     (req_ready),
        .csr_rsp_data_o      (rsp_data),
        .csr_rsp_valid_o     (rsp_valid),
        .csr_rsp_ready_i     (rsp_ready),
        .csr_reg_set_o       (reg_set),
        .csr_reg_set_valid_o (set_valid),
        .csr_reg_set_ready_i (set_ready),
        .csr_reg_ro_set_i    (ro_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge one cycle after acceptance.
    task automatic req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        int n;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_data  = data;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            nchecks++;
            nerrors++;
            $display("FAIL req_timeout: got ready=0 expected ready=1 within 50 cycles");
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req_addr  = '0;
        req_data  = '0;
        req_write = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        set_ready = 1'b1;
        ro_set    = '0;

        // Reset state
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_set_valid", 32'(set_valid), 32'd0);
        check("rst_rsp_data",  rsp_data,       32'd0);
        check("rst_set0",      reg_set[0],     32'd0);
        check("rst_set2",      reg_set[2],     32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // Back-to-back writes ending in a commit, accelerator ready
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd0; req_data = 32'd2;
        @(negedge clk);
        check("b2b_ready1", 32'(req_ready), 32'd1);
        check("b2b_setv1",  32'(set_valid), 32'd0);
        req_addr = 32'd1; req_data = 32'd16;
        @(negedge clk);
        check("b2b_ready2", 32'(req_ready), 32'd1);
        req_addr = 32'd2; req_data = 32'd1;
        @(negedge clk);
        req_valid = 1'b0;
        check("commit_setv",  32'(set_valid), 32'd1);
        check("commit_ready", 32'(req_ready), 32'd0);
        check("commit_set0",  reg_set[0],     32'd2);
        check("commit_set1",  reg_set[1],     32'd16);
        check("commit_set2",  reg_set[2],     32'd1);
        @(negedge clk);
        check("commit_setv_drop", 32'(set_valid), 32'd0);
        check("commit_ready_ret", 32'(req_ready), 32'd1);

        // Commit stalled by the accelerator; a queued read waits for the handshake
        set_ready = 1'b0;
        req(1'b1, 32'd2, 32'd5);
        check("stall_setv_start", 32'(set_valid), 32'd1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_setv",  32'(set_valid), 32'd1);
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_set2",  reg_set[2],     32'd5);
            check("stall_set0",  reg_set[0],     32'd2);
        end
        set_ready = 1'b1;
        @(negedge clk);
        check("stall_setv_drop", 32'(set_valid), 32'd0);
        check("stall_ready_ret", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("queued_rsp_valid", 32'(rsp_valid), 32'd1);
        check("queued_rsp_data",  rsp_data,       32'd2);
        @(negedge clk);

        // Table-driven reads and dropped writes; staging is {2,16,5}
        ro_set[0] = 32'h1;
        ro_set[1] = 32'h2A;
        vecs[0]  = '{1'b0, 32'd1,          32'd0,      32'd16};
        vecs[1]  = '{1'b0, 32'd3,          32'd0,      32'h1};
        vecs[2]  = '{1'b0, 32'd4,          32'd0,      32'h2A};
        vecs[3]  = '{1'b0, 32'd7,          32'd0,      32'd0};
        vecs[4]  = '{1'b0, 32'h8000_0001,  32'd0,      32'd0};
        vecs[5]  = '{1'b1, 32'd9,          32'hFFFF,   32'd0};
        vecs[6]  = '{1'b1, 32'h8000_0000,  32'd7,      32'd0};
        vecs[7]  = '{1'b0, 32'd0,          32'd0,      32'd2};
        vecs[8]  = '{1'b0, 32'd1,          32'd0,      32'd16};
        vecs[9]  = '{1'b0, 32'd2,          32'd0,      32'd5};
        vecs[10] = '{1'b1, 32'd1,          32'hABCD,   32'd0};
        vecs[11] = '{1'b0, 32'd1,          32'd0,      32'hABCD};
        for (int v = 0; v < 12; v++) begin
            req(vecs[v].wr, vecs[v].addr, vecs[v].data);
            if (vecs[v].wr) begin
                check($sformatf("vec%0d_setv", v),  32'(set_valid), 32'd0);
                check($sformatf("vec%0d_rspv", v),  32'(rsp_valid), 32'd0);
                check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'd1);
            end else begin
                check($sformatf("vec%0d_rspv", v), 32'(rsp_valid), 32'd1);
                check($sformatf("vec%0d_data", v), rsp_data,       vecs[v].exp_rd);
            end
        end
        @(negedge clk);

        // Response back-pressure while the RO register changes
        rsp_ready = 1'b0;
        req(1'b0, 32'd4, 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_rsp_data",  rsp_data,       32'h2A);
        for (int k = 0; k < 3; k++) begin
            ro_set[1] = 32'h55 + 32'(k);
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_data",  rsp_data,       32'h2A);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_rsp_drop",  32'(rsp_valid), 32'd0);
        check("bp_ready_ret", 32'(req_ready), 32'd1);

        // Asynchronous reset in the middle of a commit
        set_ready = 1'b0;
        req(1'b1, 32'd2, 32'd9);
        check("rstc_setv_pre", 32'(set_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstc_setv_async",  32'(set_valid), 32'd0);
        check("rstc_ready_async", 32'(req_ready), 32'd0);
        check("rstc_set2",        reg_set[2],     32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_ready = 1'b1;
        for (int a = 0; a < 3; a++) begin
            req(1'b0, 32'(a), 32'd0);
            check($sformatf("rstc_rd%0d_valid", a), 32'(rsp_valid), 32'd1);
            check($sformatf("rstc_rd%0d_data", a),  rsp_data,       32'd0);
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule

`default_nettype wire
